// File: rtl/softmax_pkg.sv
// softmax_pkg: shared widths, defaults and state encoding for the softmax front-end.
package softmax_pkg;
    localparam int DATA_SIZE = 32;
    localparam int FRAC_BITS = 16;
    localparam int VEC_LEN = 16;
    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRAC_BITS;
    typedef enum logic [1:0] {LOAD, PREP, EMIT} state_e;
endpackage

// File: rtl/softmax_vec_buf.sv
// softmax_vec_buf: vec_len x data_size register file, one sync write port, one async read port.
module softmax_vec_buf #(
    parameter int data_size = 32,
    parameter int vec_len = 16,
    parameter int addr_w = $clog2(vec_len)
) (
    input  logic                 clock_i,
    input  logic                 wr_en_i,
    input  logic [addr_w-1:0]    wr_addr_i,
    input  logic [data_size-1:0] wr_data_i,
    input  logic [addr_w-1:0]    rd_addr_i,
    output logic [data_size-1:0] rd_data_o
);
    logic [data_size-1:0] mem_q [vec_len];
    always_ff @(posedge clock_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end
    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/softmax_max_sub.sv
// softmax_max_sub: buffers one logit vector, finds its max, then streams max - x_i in arrival order.
module softmax_max_sub
    import softmax_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int frac_bits = FRAC_BITS,
    parameter int vec_len = VEC_LEN,
    parameter int addr_w = $clog2(vec_len)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [data_size-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic [data_size-1:0] max_o
);
    if (vec_len < 2 || frac_bits >= data_size || addr_w < 1) begin : g_bad_params
        $error("softmax_max_sub: invalid parameters");
    end

    localparam logic [addr_w-1:0] last_idx = addr_w'(vec_len - 1);

    state_e state_q, state_d;
    logic [addr_w-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_addr;
    logic [data_size-1:0] run_max_q, run_max_d, max_q, max_d;
    logic [data_size-1:0] out_data_q, out_data_d, rd_data, load_max, diff;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, in_fire, out_fire;

    assign in_fire = in_valid_i && state_q == LOAD;
    assign out_fire = out_valid_q && out_ready_i;
    assign load_max = (wr_cnt_q == '0 || $signed(in_data_i) > $signed(run_max_q)) ? in_data_i : run_max_q;
    assign rd_addr = (state_q == PREP || rd_cnt_q == last_idx) ? '0 : rd_cnt_q + 1'b1;
    // max >= x always, so the low data_size bits of the widened difference are the exact unsigned result
    assign diff = max_q - rd_data;

    softmax_vec_buf #(
        .data_size(data_size),
        .vec_len(vec_len),
        .addr_w(addr_w)
    ) u_buf (
        .clock_i(clock_i),
        .wr_en_i(in_fire),
        .wr_addr_i(wr_cnt_q),
        .wr_data_i(in_data_i),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    always_comb begin
        state_d = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        run_max_d = run_max_q;
        max_d = max_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d = out_last_q;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q == last_idx ? '0 : wr_cnt_q + 1'b1;
            run_max_d = load_max;
            max_d = wr_cnt_q == last_idx ? load_max : max_q;
            state_d = wr_cnt_q == last_idx ? PREP : LOAD;
        end
        if (state_q == PREP) begin
            out_data_d = diff;
            out_valid_d = 1'b1;
            out_last_d = 1'b0;
            rd_cnt_d = '0;
            state_d = EMIT;
        end
        if (state_q == EMIT && out_fire && rd_cnt_q != last_idx) begin
            rd_cnt_d = rd_addr;
            out_data_d = diff;
            out_last_d = rd_addr == last_idx;
        end
        if (state_q == EMIT && out_fire && rd_cnt_q == last_idx) begin
            out_valid_d = 1'b0;
            out_last_d = 1'b0;
            state_d = LOAD;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            run_max_q <= '0;
            max_q <= '0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            run_max_q <= run_max_d;
            max_q <= max_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q <= out_last_d;
        end
    end

    assign in_ready_o = state_q == LOAD;
    assign out_data_o = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o = out_last_q;
    assign max_o = max_q;
endmodule

// File: tb/tb_softmax_max_sub.sv
// tb_softmax_max_sub: scoreboard bench for softmax_max_sub with vec_len=4.
module tb_softmax_max_sub;
    localparam int DW = 32;
    localparam int VL = 4;
    localparam logic [DW-1:0] ONE = 32'h0001_0000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    logic [DW-1:0] in_data_i = '0;
    logic in_valid_i = 1'b0;
    logic in_ready_o;
    logic [DW-1:0] out_data_o;
    logic out_valid_o;
    logic out_ready_i = 1'b1;
    logic out_last_o;
    logic [DW-1:0] max_o;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] vec [VL];
    int checks = 0;
    int passed = 0;

    always #5 clock_i = ~clock_i;

    softmax_max_sub #(
        .data_size(DW),
        .frac_bits(16),
        .vec_len(VL),
        .addr_w(2)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .in_data_i(in_data_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o(out_last_o),
        .max_o(max_o)
    );

    // every output handshake is checked against the oldest expected difference
    always @(negedge clock_i) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected got data=%h last=%b", out_data_o, out_last_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data_o !== mon_e.data || out_last_o !== mon_e.last)
                    $display("FAIL out_beat got data=%h last=%b exp data=%h last=%b",
                             out_data_o, out_last_o, mon_e.data, mon_e.last);
                else passed++;
            end
        end
    end

    task automatic send_vec(input logic [DW-1:0] v [VL]);
        logic [DW-1:0] m;
        int n;
        m = v[0];
        for (int i = 1; i < VL; i++) if ($signed(v[i]) > $signed(m)) m = v[i];
        for (int i = 0; i < VL; i++) exp_q.push_back('{data: m - v[i], last: (i == VL - 1)});
        for (int i = 0; i < VL; i++) begin
            in_data_i = v[i];
            in_valid_i = 1'b1;
            n = 0;
            while (!in_ready_o && n < 200) begin
                @(negedge clock_i);
                n++;
            end
            if (!in_ready_o) begin
                checks++;
                $display("FAIL send_timeout elem=%0d in_ready=%b exp 1", i, in_ready_o);
                in_valid_i = 1'b0;
                return;
            end
            @(posedge clock_i);
            #1;
        end
        in_valid_i = 1'b0;
        checks++;
        if (max_o !== m) $display("FAIL max_o got=%h exp=%h", max_o, m);
        else passed++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready_o) && n < 500) begin
            @(negedge clock_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || !in_ready_o)
            $display("FAIL drain left=%0d in_ready=%b exp left=0 in_ready=1", exp_q.size(), in_ready_o);
        else passed++;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_last_o !== 1'b0 ||
            out_data_o !== '0 || max_o !== '0)
            $display("FAIL reset_vals got rdy=%b vld=%b last=%b data=%h max=%h exp 1 0 0 0 0",
                     in_ready_o, out_valid_o, out_last_o, out_data_o, max_o);
        else passed++;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        vec = '{32'h0001_0000, 32'h0003_0000, 32'h0002_0000, 32'hFFFF_0000};
        send_vec(vec);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0)
            $display("FAIL prep_cycle got vld=%b rdy=%b exp 0 0", out_valid_o, in_ready_o);
        else passed++;
        @(posedge clock_i);
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h0002_0000)
            $display("FAIL first_valid got vld=%b data=%h exp 1 00020000", out_valid_o, out_data_o);
        else passed++;
        drain();
    endtask

    task automatic test_full_range();
        vec = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
        send_vec(vec);
        drain();
    endtask

    task automatic test_stall();
        out_ready_i = 1'b0;
        vec = '{3 * ONE, 1 * ONE, 6 * ONE, 2 * ONE};
        send_vec(vec);
        @(posedge clock_i);
        #1;
        out_ready_i = 1'b1;
        @(posedge clock_i);
        #1;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 5 * ONE || out_last_o !== 1'b0)
                $display("FAIL stall_hold cyc=%0d got vld=%b data=%h last=%b exp 1 %h 0",
                         i, out_valid_o, out_data_o, out_last_o, 5 * ONE);
            else passed++;
        end
        @(posedge clock_i);
        #1;
        out_ready_i = 1'b1;
        drain();
    endtask

    task automatic test_ignore_input();
        int n;
        out_ready_i = 1'b1;
        vec = '{1 * ONE, 2 * ONE, 3 * ONE, 4 * ONE};
        send_vec(vec);
        in_data_i = 32'h0005_0000;
        in_valid_i = 1'b1;
        n = 0;
        @(negedge clock_i);
        while (!in_ready_o && n < 100) begin
            @(negedge clock_i);
            n++;
        end
        checks++;
        if (!in_ready_o || exp_q.size() != 0 || max_o !== 4 * ONE)
            $display("FAIL ignore_input got rdy=%b left=%0d max=%h exp 1 0 %h",
                     in_ready_o, exp_q.size(), max_o, 4 * ONE);
        else passed++;
        vec = '{5 * ONE, 5 * ONE, 5 * ONE, 5 * ONE};
        send_vec(vec);
        drain();
    endtask

    task automatic test_reset_mid();
        in_data_i = 9 * ONE;
        in_valid_i = 1'b1;
        @(posedge clock_i);
        #1;
        in_data_i = 2 * ONE;
        @(posedge clock_i);
        #1;
        in_valid_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || max_o !== '0)
            $display("FAIL reset_mid got rdy=%b vld=%b max=%h exp 1 0 0", in_ready_o, out_valid_o, max_o);
        else passed++;
        vec = '{ONE, ONE, ONE, ONE};
        send_vec(vec);
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        vec = '{1 * ONE, 2 * ONE, 3 * ONE, 4 * ONE};
        send_vec(vec);
        vec = '{4 * ONE, 3 * ONE, 2 * ONE, 1 * ONE};
        send_vec(vec);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_stall();
        test_ignore_input();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clock_i);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
